mux_select_debounce: RTL and testbench
======================================

# mux_select_debounce

Pushbutton-to-select controller that drives the `s` input of the 2:1 lab multiplexer. It synchronizes a raw board pushbutton, debounces it, and toggles a registered select line once per clean press. The `y` path is selected after reset (`s`=0), and each press alternates between the `x` and `y` inputs. A one-cycle press strobe is also provided for downstream logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-stable cycles required to accept a press or a release; legal range ≥ 2.
- `AUTO_PERIOD`, default 8: cycles between automatic toggles. Present only with `AUTO_TOGGLE_EN`. Legal range ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `btn` input 1: raw asynchronous pushbutton, active-high.
- `auto_mode` input 1: enables automatic toggling. Present only with `AUTO_TOGGLE_EN`.
- `s` output 1: registered mux select; 0 selects `y`, 1 selects `x`.
- `press` output 1: one-cycle strobe, high in the cycle `s` changes because of a button press.

## Operation
- `btn` passes through a 2-flop synchronizer to produce `btn_s`. Raw glitches shorter than one clock have no effect.
- Debounce counter width: `$clog2(DEBOUNCE_CYCLES+1)`. The counter never wraps; it clears on every state change.
- FSM states: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE: if `btn_s`=1, go to WAIT_PRESS with count=1.
  - WAIT_PRESS, `btn_s`=0: go to IDLE and clear the count. This handles bounce.
  - WAIT_PRESS, `btn_s`=1 and count=DEBOUNCE_CYCLES-1: go to PRESSED, toggle `s`, assert `press` for one cycle.
  - WAIT_PRESS, `btn_s`=1 otherwise: increment the count.
  - PRESSED: stay while `btn_s`=1; no further toggles however long the button is held. If `btn_s`=0, go to WAIT_RELEASE with count=1.
  - WAIT_RELEASE, `btn_s`=1: return to PRESSED with no toggle.
  - WAIT_RELEASE, `btn_s`=0 and count=DEBOUNCE_CYCLES-1: go to IDLE.
- Exactly one toggle per accepted press-release cycle.
- Reset values: `s`=0, `press`=0, FSM=IDLE, all counters 0, synchronizer flops 0. Reset takes priority over every other event in the same cycle.
- Reset mid-debounce or mid-hold: the FSM returns to IDLE. A button still held after reset must be re-qualified as a new press, so holding the button through reset produces one toggle after reset deasserts.

## Timing
- Press latency: `s` toggles DEBOUNCE_CYCLES rising edges after the first edge where `btn_s`=1. Measured from the first edge sampling a stable raw `btn`=1, latency is DEBOUNCE_CYCLES+2 edges.
- `press` is high during the single cycle following the toggling edge, aligned with the new `s` value.
- Minimum clean press-to-press interval: 2·DEBOUNCE_CYCLES + 4 cycles.
- `s` changes only on clock edges, so the downstream mux output changes at most once per press.

## Configuration
- `AUTO_TOGGLE_EN` defined:
  - Adds the `auto_mode` port, the `AUTO_PERIOD` parameter and a period counter of width `$clog2(AUTO_PERIOD)`.
  - While `auto_mode`=1 and FSM=IDLE, `s` toggles every AUTO_PERIOD cycles and `press` stays 0.
  - The period counter clears when `auto_mode`=0, when the FSM leaves IDLE, and on reset.
  - If an automatic toggle and a press toggle fall in the same cycle, exactly one toggle occurs and `press`=1.
- `AUTO_TOGGLE_EN` undefined: no port, parameter or counter; `s` changes only on button presses.

## Structure
- A shared package or header holds the FSM state localparams (2-bit encoding: IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3) and the default DEBOUNCE_CYCLES value.
- Sub-module `sync_2ff` is a generic 1-bit two-flop synchronizer, reset to 0 by the same synchronous `reset`.
- The FSM, debounce counter and select register live in the top module.

## Test plan
- Reset: assert `reset` for 3 cycles with `btn`=1 → `s`=0, `press`=0 during reset; after release, `s` reaches 1 exactly DEBOUNCE_CYCLES+2 edges later.
- Clean press (DEBOUNCE_CYCLES=4): `btn` high for 20 cycles, then low for 20 → `s` goes 0→1 at edge 6, `press` high for 1 cycle, no further toggle.
- Bounce: `btn` pattern 1,0,1,1,0,1 before settling high → one toggle only, timed from the final rising edge of `btn_s`.
- Release bounce: during release, `btn` toggles 0,1,0 for 3 cycles → no extra toggle; FSM reaches IDLE; a second clean press returns `s` to 0.
- Reset mid-debounce: assert `reset` 2 cycles into WAIT_PRESS → `s` stays 0, FSM=IDLE, counter=0.
- With `AUTO_TOGGLE_EN`, `AUTO_PERIOD`=8: `auto_mode`=1 for 32 cycles → 4 toggles of `s`, `press` always 0; a press during this window suspends auto toggling until the FSM returns to IDLE.

Source files
------------

// File: rtl/mux_select_debounce_pkg.sv
// mux_select_debounce shared types and defaults.
// FSM encoding is fixed: IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3.
package mux_select_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam int DEBOUNCE_DEFAULT    = 4;
  localparam int AUTO_PERIOD_DEFAULT = 8;

endpackage

// File: rtl/mux_select_debounce_if.sv
// Button/select bundle between board logic and mux_select_debounce.
// auto_mode exists only when AUTO_TOGGLE_EN is defined.
interface mux_select_debounce_if;

  logic btn;
  logic s;
  logic press;
`ifdef AUTO_TOGGLE_EN
  logic auto_mode;

  modport master (
    output btn,
    output auto_mode,
    input  s,
    input  press
  );

  modport slave (
    input  btn,
    input  auto_mode,
    output s,
    output press
  );
`else
  modport master (
    output btn,
    input  s,
    input  press
  );

  modport slave (
    input  btn,
    output s,
    output press
  );
`endif

endinterface

// File: rtl/mux_select_debounce_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous
// active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/mux_select_debounce.sv
// Pushbutton-driven mux select: sync, debounce, toggle s per press.
// Optional AUTO_TOGGLE_EN adds periodic toggling while idle.
module mux_select_debounce
  import mux_select_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef AUTO_TOGGLE_EN
  ,
  parameter int AUTO_PERIOD = AUTO_PERIOD_DEFAULT
`endif
) (
  input logic                   clk,
  input logic                   reset,
  mux_select_debounce_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          btn_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_q, s_d;
  logic          press_q, press_d;
  logic          press_tog;
  logic          auto_tog;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.btn),
    .q_o   (btn_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_tog = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          press_tog = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTO_TOGGLE_EN
  localparam int PW = $clog2(AUTO_PERIOD);
  localparam logic [PW-1:0] PER_LAST =
    PW'(AUTO_PERIOD - 1);

  logic [PW-1:0] per_q, per_d;
  logic          per_run;

  // Period only advances while idle with auto_mode set.
  always_comb begin
    per_run  = bus.auto_mode && (state_q == IDLE);
    auto_tog = per_run && (per_q == PER_LAST);
    per_d    = '0;
    if (per_run && !auto_tog) begin
      per_d = per_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end
`else
  assign auto_tog = 1'b0;
`endif

  always_comb begin
    s_d     = s_q ^ (press_tog | auto_tog);
    press_d = press_tog;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      press_q <= press_d;
    end
  end

  assign bus.s     = s_q;
  assign bus.press = press_q;

endmodule

// File: tb/tb_mux_select_debounce.sv
// Self-checking bench for mux_select_debounce: directed
// scenarios plus random button traffic against a run-length model.
module tb_mux_select_debounce;

  localparam int DC = 4;
  localparam int AP = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux_select_debounce_if bus ();

  mux_select_debounce #(
    .DEBOUNCE_CYCLES (DC)
`ifdef AUTO_TOGGLE_EN
    ,
    .AUTO_PERIOD (AP)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: btn_s is raw btn delayed two edges; a press is
  // accepted after DC consecutive 1s while armed, and the
  // button re-arms after DC consecutive 0s.
  bit m_sync1, m_sync2;
  int ones, zeros;
  bit armed;
  bit m_s, m_press;
  bit m_auto;
  int per;

  int tog_cnt, press_cnt, tick_idx, last_tog;
  logic prev_s;

  task automatic check(input string tag,
                       input logic obs,
                       input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag,
                        input int obs,
                        input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit b, input bit r);
    bit bs;
    bit idle_pre;
    if (r) begin
      m_sync1 = 0; m_sync2 = 0;
      ones = 0; zeros = 0; armed = 1;
      m_s = 0; m_press = 0; per = 0;
    end else begin
      bs = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = b;
      idle_pre = armed && (ones == 0);
      if (bs) begin
        ones++; zeros = 0;
      end else begin
        zeros++; ones = 0;
      end
      m_press = 0;
      if (armed && ones == DC) begin
        m_s = !m_s; m_press = 1; armed = 0;
      end else if (!armed && zeros == DC) begin
        armed = 1;
      end
`ifdef AUTO_TOGGLE_EN
      if (m_auto && idle_pre) begin
        per++;
        if (per == AP) begin
          per = 0;
          if (!m_press) m_s = !m_s;
        end
      end else begin
        per = 0;
      end
`else
      if (idle_pre && m_auto) per++;
`endif
    end
  endtask

  task automatic clr_stats();
    tog_cnt = 0; press_cnt = 0;
    tick_idx = 0; last_tog = 0;
  endtask

  task automatic tick(input logic b, input logic r);
    bus.btn = b;
    reset   = r;
`ifdef AUTO_TOGGLE_EN
    bus.auto_mode = m_auto;
`endif
    prev_s = bus.s;
    @(posedge clk);
    model_edge(b, r);
    #1;
    tick_idx++;
    if (bus.s !== prev_s) begin
      tog_cnt++;
      last_tog = tick_idx;
    end
    if (bus.press === 1'b1) press_cnt++;
    check("s_vs_model", bus.s, m_s);
    check("press_vs_model", bus.press, m_press);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b0);
  endtask

  logic s_save;
  bit rb;

  initial begin
    bus.btn = 1'b0;
    reset   = 1'b1;
    m_auto  = 0;
`ifdef AUTO_TOGGLE_EN
    bus.auto_mode = 1'b0;
`endif

    // Reset with button held, then re-qualification.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("rst_s", bus.s, 1'b0);
    check("rst_press", bus.press, 1'b0);
    checki("rst_state", 32'(dut.state_q), 0);
    clr_stats();
    hold(1'b1, 20);
    checki("rst_hold_toggles", tog_cnt, 1);
    checki("rst_hold_latency", last_tog, DC + 2);
    hold(1'b0, 20);

    // Clean press.
    clr_stats();
    hold(1'b1, 20);
    checki("clean_latency", last_tog, 6);
    checki("clean_press_cnt", press_cnt, 1);
    hold(1'b0, 20);
    checki("clean_toggles", tog_cnt, 1);
    check("clean_s", bus.s, 1'b0);

    // Press bounce.
    clr_stats();
    tick(1, 0); tick(0, 0); tick(1, 0);
    tick(1, 0); tick(0, 0); tick(1, 0);
    hold(1'b1, 15);
    checki("bounce_toggles", tog_cnt, 1);
    checki("bounce_latency", last_tog, 11);
    hold(1'b0, 20);

    // Release bounce.
    hold(1'b1, 15);
    clr_stats();
    tick(0, 0); tick(1, 0); tick(0, 0);
    hold(1'b0, 20);
    checki("rel_bounce_toggles", tog_cnt, 0);
    checki("rel_bounce_idle", 32'(dut.state_q), 0);
    s_save = bus.s;
    hold(1'b1, 15);
    check("second_press_s", bus.s, ~s_save);
    hold(1'b0, 20);

    // Reset two cycles into WAIT_PRESS.
    s_save = bus.s;
    hold(1'b1, 4);
    checki("mid_wp_state", 32'(dut.state_q), 1);
    tick(1'b1, 1'b1);
    checki("mid_rst_state", 32'(dut.state_q), 0);
    checki("mid_rst_cnt", 32'(dut.cnt_q), 0);
    check("mid_rst_s", bus.s, 1'b0);
    hold(1'b0, 20);
    check("mid_rst_s_after", bus.s, 1'b0);

    // Random bouncy traffic with occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      rb = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        tick(rb, 1'b1);
      end else begin
        hold(rb, int'($urandom_range(1, 12)));
      end
    end
    hold(1'b0, 20);

`ifdef AUTO_TOGGLE_EN
    m_auto = 1;
    clr_stats();
    hold(1'b0, 32);
    checki("auto_toggles", tog_cnt, 4);
    checki("auto_press_cnt", press_cnt, 0);
    clr_stats();
    hold(1'b1, 20);
    checki("auto_suspend_toggles", tog_cnt, 1);
    checki("auto_suspend_press", press_cnt, 1);
    hold(1'b0, 24);
    m_auto = 0;
    hold(1'b0, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
